// File: rtl/debounce_scanner_if.sv
// Button-side bundle of the debounce scanner: raw levels in, accepted levels and event pulses out.
`timescale 1ns/1ps

interface debounce_scanner_if #(
    parameter int N_INPUTS = 4
);
    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    // pressed/released carry no handshake: each bit is a single-cycle pulse, coincident
    // with the debounced_out edge it reports, and at most one bit of either is high per cycle.
    logic [N_INPUTS-1:0] bouncy_in;
    logic [N_INPUTS-1:0] debounced_out;
    logic [N_INPUTS-1:0] pressed;
    logic [N_INPUTS-1:0] released;
    logic [IDX_W-1:0]    scan_idx;

    modport master (
        output bouncy_in,
        input  debounced_out,
        input  pressed,
        input  released,
        input  scan_idx
    );

    modport slave (
        input  bouncy_in,
        output debounced_out,
        output pressed,
        output released,
        output scan_idx
    );
endinterface

// File: rtl/debounce_scanner.sv
// Time-multiplexed debouncer: one round-robin slot scheduler samples one synchronized input per
// slot and accepts a new level after STABLE_SAMPLES consecutive differing samples.
`timescale 1ns/1ps

module debounce_scanner #(
    parameter int N_INPUTS       = 4,
    parameter int SCAN_TICKS     = 1000,
    parameter int STABLE_SAMPLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    debounce_scanner_if.slave bus
);
    localparam int IDX_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int CNT_W  = $clog2(STABLE_SAMPLES + 1);

    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(SCAN_TICKS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_INPUTS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(STABLE_SAMPLES - 1);

    logic [N_INPUTS-1:0] sync_meta;
    logic [N_INPUTS-1:0] sync_q;
    logic [N_INPUTS-1:0] level;
    logic [N_INPUTS-1:0] press_q;
    logic [N_INPUTS-1:0] release_q;
    logic [TICK_W-1:0]   tick;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    count [N_INPUTS];

    logic             slot;
    logic             sample;
    logic             cur_level;
    logic [CNT_W-1:0] cur_count;
    logic             differ;
    logic             accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= bus.bouncy_in;
            sync_q    <= sync_meta;
        end
    end

    assign slot = ena && (tick == LAST_TICK);

    // Scheduler: tick counter and visited index both hold while ena is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick <= '0;
            idx  <= '0;
        end else if (ena) begin
            if (tick == LAST_TICK) begin
                tick <= '0;
                idx  <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end else begin
                tick <= tick + TICK_W'(1);
            end
        end
    end

    always_comb begin
        sample    = 1'b0;
        cur_level = 1'b0;
        cur_count = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (idx == IDX_W'(i)) begin
                sample    = sync_q[i];
                cur_level = level[i];
                cur_count = count[i];
            end
        end
    end

    assign differ = (sample != cur_level);
    assign accept = slot && differ && (cur_count == LAST_CNT);

    // Any sample that agrees with the accepted level restarts that input's run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                count[i] <= '0;
            end
        end else if (slot) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (idx == IDX_W'(i)) begin
                    if (!differ || (cur_count == LAST_CNT)) begin
                        count[i] <= '0;
                    end else begin
                        count[i] <= cur_count + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Level and pulse are registered on the same edge so the pulse marks the level change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level     <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            press_q   <= '0;
            release_q <= '0;
            if (accept) begin
                for (int i = 0; i < N_INPUTS; i++) begin
                    if (idx == IDX_W'(i)) begin
                        level[i]     <= sample;
                        press_q[i]   <= sample;
                        release_q[i] <= !sample;
                    end
                end
            end
        end
    end

    assign bus.debounced_out = level;
    assign bus.pressed       = press_q;
    assign bus.released      = release_q;
    assign bus.scan_idx      = idx;
endmodule

// File: tb/tb_debounce_scanner.sv
// Scoreboarded bench for debounce_scanner: a visit-window reference model predicts every pulse,
// a negedge monitor pops and compares, directed and random scenarios drive the inputs.
`timescale 1ns/1ps

module tb_debounce_scanner;
    localparam int N     = 4;
    localparam int ST    = 2;
    localparam int SS    = 4;
    localparam int IDX_W = 2;
    localparam int W     = 32 + 2 * N;

    logic clk;
    logic rst;
    logic ena;

    debounce_scanner_if #(.N_INPUTS(N)) dbi ();

    debounce_scanner #(
        .N_INPUTS      (N),
        .SCAN_TICKS    (ST),
        .STABLE_SAMPLES(SS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ena(ena),
        .bus(dbi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: visits counted from reset, sample windows per input.
    int          en_edges;
    int          slots;
    bit [N-1:0]  m_level;
    bit [N-1:0]  smp_d1;
    bit [N-1:0]  smp_d2;
    bit [SS-1:0] win  [N];
    int          nvis [N];
    logic [W-1:0] exp_q[$];

    int press_cnt [N];
    int rel_cnt   [N];
    int press_cyc [N];
    int rel_cyc   [N];

    task automatic model_clear();
        m_level  = '0;
        smp_d1   = '0;
        smp_d2   = '0;
        en_edges = 0;
        slots    = 0;
        for (int i = 0; i < N; i++) begin
            win[i]  = '0;
            nvis[i] = 0;
        end
        exp_q.delete();
    endtask

    // A slot is every ST-th enabled edge; it sees the input as it was two edges earlier and
    // visits inputs in turn. A new level is accepted once the last SS visits since the
    // previous acceptance all disagree with the current level.
    task automatic model_step();
        bit [N-1:0]   s_now;
        int           k;
        logic [W-1:0] e;
        s_now  = smp_d2;
        smp_d2 = smp_d1;
        smp_d1 = dbi.bouncy_in;
        if (ena) begin
            if ((en_edges % ST) == ST - 1) begin
                k = slots % N;
                win[k] = {win[k][SS-2:0], s_now[k]};
                nvis[k]++;
                if (nvis[k] >= SS && win[k] == {SS{~m_level[k]}}) begin
                    m_level[k] = s_now[k];
                    e = '0;
                    e[W-1 -: 32] = cyc;
                    if (s_now[k]) e[N + k] = 1'b1;
                    else          e[k]     = 1'b1;
                    exp_q.push_back(e);
                    nvis[k] = 0;
                end
                slots++;
            end
            en_edges++;
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) model_clear();
            else      model_step();
        end
    end

    initial begin
        logic [W-1:0]     act;
        logic [W-1:0]     e;
        logic [IDX_W-1:0] exp_idx;
        forever begin
            @(negedge clk);
            if (rst) begin
                checks++;
                if (dbi.debounced_out !== m_level) begin
                    errors++;
                    $display("FAIL level cyc=%0d got=%b exp=%b", cyc, dbi.debounced_out, m_level);
                end
                exp_idx = IDX_W'(slots % N);
                checks++;
                if (dbi.scan_idx !== exp_idx) begin
                    errors++;
                    $display("FAIL scan_idx cyc=%0d got=%0d exp=%0d", cyc, dbi.scan_idx, exp_idx);
                end
                if ((dbi.pressed | dbi.released) !== '0) begin
                    for (int i = 0; i < N; i++) begin
                        if (dbi.pressed[i] === 1'b1)  begin press_cnt[i]++; press_cyc[i] = cyc; end
                        if (dbi.released[i] === 1'b1) begin rel_cnt[i]++;   rel_cyc[i]   = cyc; end
                    end
                    act = {cyc, dbi.pressed, dbi.released};
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL pulse_unexpected cyc=%0d got pressed=%b released=%b exp none",
                                 cyc, dbi.pressed, dbi.released);
                    end else begin
                        e = exp_q.pop_front();
                        if (act !== e) begin
                            errors++;
                            $display("FAIL pulse cyc=%0d got pressed=%b released=%b exp pressed=%b released=%b at cyc %0d",
                                     cyc, dbi.pressed, dbi.released, e[2*N-1:N], e[N-1:0], e[W-1 -: 32]);
                        end
                    end
                end else if (exp_q.size() != 0 && int'(exp_q[0][W-1 -: 32]) < cyc) begin
                    checks++;
                    errors++;
                    e = exp_q.pop_front();
                    $display("FAIL pulse_missing cyc=%0d got none exp pressed=%b released=%b at cyc %0d",
                             cyc, e[2*N-1:N], e[N-1:0], e[W-1 -: 32]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got no finish exp finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input bit ok, input longint act, input longint expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int total_pulses();
        int t;
        t = 0;
        for (int i = 0; i < N; i++) t += press_cnt[i] + rel_cnt[i];
        return t;
    endfunction

    task automatic async_reset(input int low_cycles);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_async_debounced", dbi.debounced_out == '0, dbi.debounced_out, 0);
        chk("rst_async_pressed",   dbi.pressed == '0,       dbi.pressed,       0);
        chk("rst_async_released",  dbi.released == '0,      dbi.released,      0);
        chk("rst_async_scan_idx",  dbi.scan_idx == '0,      dbi.scan_idx,      0);
        repeat (low_cycles) tick();
        rst = 1'b1;
    endtask

    task automatic wait_pulse(input int b, input bit rise, input int budget,
                              output int at, output bit ok);
        int c0;
        c0 = rise ? press_cnt[b] : rel_cnt[b];
        ok = 1'b0;
        at = 0;
        for (int k = 0; k < budget && !ok; k++) begin
            tick();
            if ((rise ? press_cnt[b] : rel_cnt[b]) != c0) begin
                ok = 1'b1;
                at = rise ? press_cyc[b] : rel_cyc[b];
            end
        end
    endtask

    initial begin
        int   t0, at, l0, l1, tp, pc3, pb, rb, b, n, tmp;
        bit   ok, fin, frozen_ok;
        int   pc [N];
        int   oc [N];
        int   ob [N];
        logic [IDX_W-1:0] frozen_idx;
        logic [N-1:0]     frozen_lvl;

        rst = 1'b0;
        ena = 1'b1;
        dbi.bouncy_in = '0;
        repeat (3) tick();
        chk("reset_debounced", dbi.debounced_out == '0, dbi.debounced_out, 0);
        chk("reset_pressed",   dbi.pressed == '0,       dbi.pressed,       0);
        chk("reset_released",  dbi.released == '0,      dbi.released,      0);
        chk("reset_scan_idx",  dbi.scan_idx == '0,      dbi.scan_idx,      0);
        rst = 1'b1;
        repeat (6) tick();

        // Clean rise then clean fall on bit 2.
        tp = total_pulses();
        dbi.bouncy_in = 4'b0100;
        t0 = cyc;
        wait_pulse(2, 1'b1, 60, at, ok);
        chk("rise_seen", ok, ok, 1);
        chk("rise_latency", ok && (at - t0) >= 27 && (at - t0) <= 35, at - t0, 27);
        chk("rise_level", dbi.debounced_out == 4'b0100, dbi.debounced_out, 4);
        repeat (10) tick();
        dbi.bouncy_in = '0;
        t0 = cyc;
        wait_pulse(2, 1'b0, 60, at, ok);
        chk("fall_seen", ok, ok, 1);
        chk("fall_latency", ok && (at - t0) >= 27 && (at - t0) <= 35, at - t0, 27);
        chk("clean_pulse_total", total_pulses() - tp == 2, total_pulses() - tp, 2);

        // Short glitch on bit 0 must be rejected.
        repeat (10) tick();
        tp = total_pulses();
        dbi.bouncy_in[0] = 1'b1;
        repeat (16) tick();
        dbi.bouncy_in[0] = 1'b0;
        repeat (60) tick();
        chk("glitch_no_pulse", total_pulses() == tp, total_pulses() - tp, 0);
        chk("glitch_level", dbi.debounced_out[0] == 1'b0, dbi.debounced_out[0], 0);

        // All four step together: acceptances land on consecutive slots in scan order.
        for (int i = 0; i < N; i++) pc[i] = press_cnt[i];
        dbi.bouncy_in = 4'hF;
        repeat (50) tick();
        for (int i = 0; i < N; i++) begin
            chk("all_press_count", press_cnt[i] - pc[i] == 1, press_cnt[i] - pc[i], 1);
            oc[i] = press_cyc[i];
            ob[i] = i;
        end
        for (int i = 0; i < N - 1; i++) begin
            for (int j = 0; j < N - 1 - i; j++) begin
                if (oc[j] > oc[j+1]) begin
                    tmp = oc[j]; oc[j] = oc[j+1]; oc[j+1] = tmp;
                    tmp = ob[j]; ob[j] = ob[j+1]; ob[j+1] = tmp;
                end
            end
        end
        for (int k = 0; k < N - 1; k++) begin
            chk("all_spacing", oc[k+1] - oc[k] == ST, oc[k+1] - oc[k], ST);
            chk("all_order", ob[k+1] == (ob[k] + 1) % N, ob[k+1], (ob[k] + 1) % N);
        end
        dbi.bouncy_in = '0;
        repeat (50) tick();

        // Reference latency for bit 1, then the same run with a 50-cycle enable stall.
        async_reset(3);
        repeat (5) tick();
        dbi.bouncy_in[1] = 1'b1;
        t0 = cyc;
        wait_pulse(1, 1'b1, 80, at, ok);
        chk("ref_seen", ok, ok, 1);
        l0 = at - t0;
        dbi.bouncy_in = '0;
        repeat (50) tick();

        async_reset(3);
        repeat (5) tick();
        dbi.bouncy_in[1] = 1'b1;
        t0 = cyc;
        repeat (12) tick();
        ena = 1'b0;
        frozen_idx = dbi.scan_idx;
        frozen_lvl = dbi.debounced_out;
        frozen_ok  = 1'b1;
        repeat (50) begin
            tick();
            if (dbi.scan_idx !== frozen_idx || dbi.debounced_out !== frozen_lvl) frozen_ok = 1'b0;
        end
        chk("stall_frozen", frozen_ok, frozen_ok, 1);
        ena = 1'b1;
        wait_pulse(1, 1'b1, 80, at, ok);
        l1 = at - t0;
        chk("stall_seen", ok, ok, 1);
        chk("stall_delay", ok && l1 == l0 + 50, l1, l0 + 50);
        dbi.bouncy_in = '0;
        repeat (50) tick();

        // Reset while bit 3 is mid-count and bit 0 is already accepted.
        dbi.bouncy_in = 4'b0001;
        repeat (50) tick();
        chk("pre_rst_level", dbi.debounced_out == 4'b0001, dbi.debounced_out, 1);
        dbi.bouncy_in = 4'b1001;
        repeat (12) tick();
        pc3 = press_cnt[3];
        async_reset(3);
        t0 = cyc;
        wait_pulse(3, 1'b1, 60, at, ok);
        chk("post_rst_seen", ok, ok, 1);
        chk("post_rst_latency", ok && (at - t0) >= 27 && (at - t0) <= 35, at - t0, 27);
        repeat (20) tick();
        chk("post_rst_one_press", press_cnt[3] - pc3 == 1, press_cnt[3] - pc3, 1);
        chk("post_rst_level", dbi.debounced_out == 4'b1001, dbi.debounced_out, 9);
        dbi.bouncy_in = '0;
        repeat (50) tick();

        // Random bounce bursts, each followed by a settled level.
        for (int r = 0; r < 4; r++) begin
            b   = $urandom_range(0, N - 1);
            n   = $urandom_range(10, 30);
            fin = 1'($urandom_range(0, 1));
            pb  = press_cnt[b];
            rb  = rel_cnt[b];
            for (int k = 0; k < n; k++) begin
                dbi.bouncy_in[b] = ~dbi.bouncy_in[b];
                repeat ($urandom_range(1, 15)) tick();
            end
            dbi.bouncy_in[b] = fin;
            repeat (250) tick();
            chk("bounce_level", dbi.debounced_out[b] == fin, dbi.debounced_out[b], fin);
            chk("bounce_press_max", press_cnt[b] - pb <= 1, press_cnt[b] - pb, 1);
            chk("bounce_release_max", rel_cnt[b] - rb <= 1, rel_cnt[b] - rb, 1);
        end

        repeat (5) tick();
        chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/debounce_scanner.md
Name: debounce_scanner

Overview:
- Debounces N button inputs with one time-multiplexed scan scheduler instead of N free-running debouncers.
- A round-robin slot scheduler visits one input per scan slot and keeps a per-input stable-sample counter.
- Produces a debounced level per input, plus one-cycle press/release event pulses for the RGB sequencer mode logic.
- Sits between the board buttons and the sequencer FSM.

Parameters:
- N_INPUTS, 4, number of bouncy inputs scanned (legal: >=1).
- SCAN_TICKS, 1000, clk cycles per scan slot (legal: >=1).
- STABLE_SAMPLES, 8, consecutive differing samples required to accept a new level (legal: >=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset; all state cleared while low.
- ena  input  1  scan enable; low freezes the scheduler.
- bouncy_in  input  N_INPUTS  raw asynchronous button levels.
- debounced_out  output  N_INPUTS  accepted stable levels.
- pressed  output  N_INPUTS  one-cycle pulse on accepted 0->1.
- released  output  N_INPUTS  one-cycle pulse on accepted 1->0.
- scan_idx  output  max(1,$clog2(N_INPUTS))  index visited by the current slot.

Behaviour:
- Reset (rst low, async):
  - debounced_out, pressed, released, scan_idx, tick counter and all sample counters = 0.
  - Synchronizer flops = 0.
- Synchronizer: each bouncy_in bit passes through 2 flops (sync). Only sync values are sampled.
- Tick counter: counts 0..SCAN_TICKS-1 while ena=1, then wraps to 0.
  - A slot fires on the cycle the counter equals SCAN_TICKS-1 and ena=1.
  - With SCAN_TICKS=1, every enabled cycle is a slot.
- On a slot:
  - Let i = scan_idx and s = sync[i].
  - scan_idx advances; N_INPUTS-1 wraps to 0. With N_INPUTS=1, scan_idx stays 0.
- Per-input counter, count[i], width $clog2(STABLE_SAMPLES+1):
  - s == debounced_out[i]: count[i] <= 0.
  - s != debounced_out[i] and count[i]+1 < STABLE_SAMPLES: count[i] <= count[i]+1.
  - s != debounced_out[i] and count[i]+1 == STABLE_SAMPLES: debounced_out[i] <= s, count[i] <= 0, and pressed[i] (s=1) or released[i] (s=0) is asserted for exactly the next cycle.
- Only one input is updated per slot, so at most one pressed/released bit is high in any cycle.
- Pulses are registered: they are high on the same cycle debounced_out changes, and low on all other cycles.
- Acceptance latency after a clean input step:
  - Minimum: 2 + (STABLE_SAMPLES-1)*N_INPUTS*SCAN_TICKS + 1 cycles.
  - Maximum: 2 + STABLE_SAMPLES*N_INPUTS*SCAN_TICKS + 1 cycles.
- Any sample that matches the current level restarts the count. A glitch is therefore rejected if it lasts fewer than (STABLE_SAMPLES-1)*N_INPUTS*SCAN_TICKS cycles.
- ena=0:
  - Tick counter, scan_idx and counts hold; no slots fire.
  - debounced_out holds; pressed/released = 0.
  - The synchronizer keeps running.
  - When ena is raised again, the tick counter resumes from its held value.
- ena low on the same cycle a slot would fire: the slot does not fire.
- Reset mid-count: all counts clear. An input held high across reset release is re-accepted after the full latency and produces a pressed pulse.

Test Plan:
- Test parameters for all scenarios: N_INPUTS=4, SCAN_TICKS=2, STABLE_SAMPLES=4, so each input is visited every 8 cycles.
- Clean rise on bit 2 at cycle T -> debounced_out[2] rises between T+27 and T+35; pressed[2] high exactly 1 cycle, coincident with the rise; all other outputs stay 0. Then a clean fall -> released[2] pulse with the same bounds.
- Bit 0 high for 16 cycles, then low (at most 3 differing samples) -> debounced_out[0] never changes; no pulses.
- Bits 0-3 step high on the same cycle -> all four accept; the four pressed pulses occur on four distinct cycles spaced 2 cycles apart, in scan order from scan_idx.
- Bit 1 held high; deassert ena for 50 cycles midway through counting -> scan_idx and debounced_out frozen during that window; acceptance is delayed by exactly 50 cycles versus the unstalled run.
- rst low for 3 cycles mid-count with bit 3 high -> all outputs 0 immediately (async); after release, debounced_out[3] rises within the latency bounds with one pressed[3] pulse.
- Random bounce (1-15 cycle intervals, 10-30 toggles) then stable level for 250 cycles -> debounced_out equals the final level; at most one pulse per settled direction.
